// File: rtl/wb_port_arbiter_if.sv
// Handshake and write-port bundle shared by the WB stage, the MDU result
// path and the register-file write port of wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned DBITS      = 32,
  parameter int unsigned REGNOBITS  = 5,
  parameter int unsigned FIFO_DEPTH = 2
);
  logic                               pipe_valid;
  logic                               pipe_wr_reg;
  logic [REGNOBITS-1:0]               pipe_wregno;
  logic [DBITS-1:0]                   pipe_regval;
  logic                               pipe_ready;
  logic                               mdu_valid;
  logic [REGNOBITS-1:0]               mdu_wregno;
  logic [DBITS-1:0]                   mdu_regval;
  logic                               mdu_ready;
  logic                               rf_we;
  logic [REGNOBITS-1:0]               rf_wregno;
  logic [DBITS-1:0]                   rf_wdata;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    mdu_pending;

  modport master (
    output pipe_valid, pipe_wr_reg, pipe_wregno, pipe_regval,
    output mdu_valid, mdu_wregno, mdu_regval,
    input  pipe_ready, mdu_ready, rf_we, rf_wregno, rf_wdata, mdu_pending
  );

  modport slave (
    input  pipe_valid, pipe_wr_reg, pipe_wregno, pipe_regval,
    input  mdu_valid, mdu_wregno, mdu_regval,
    output pipe_ready, mdu_ready, rf_we, rf_wregno, rf_wdata, mdu_pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order WB stage and a
// small FIFO of MDU results; stalls WB when the buffered MDU result must win.
module wb_port_arbiter #(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned REGNOBITS    = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [REGNOBITS-1:0] fifo_regno [FIFO_DEPTH];
  logic [DBITS-1:0]     fifo_data  [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;

  logic                 head_valid, full, need_pipe, starved, mdu_wins;
  logic                 grant_mdu, grant_pipe, push, pop;
  logic [REGNOBITS-1:0] head_regno;
  logic [DBITS-1:0]     head_data;

  always_comb begin
    head_valid = (count != '0);
    full       = (count == CW'(FIFO_DEPTH));
    head_regno = fifo_regno[rd_ptr];
    head_data  = fifo_data[rd_ptr];
    need_pipe  = bus.pipe_valid && bus.pipe_wr_reg && (bus.pipe_wregno != '0);
    starved    = (starve_cnt >= SW'(STARVE_LIMIT));
    // Same-register match forces the older MDU write first to keep program order.
    mdu_wins   = need_pipe && head_valid &&
                 (starved || full || (head_regno == bus.pipe_wregno));
    grant_mdu  = need_pipe ? mdu_wins : head_valid;
    grant_pipe = need_pipe && !mdu_wins;
    push       = bus.mdu_valid && !full;
    pop        = grant_mdu;
  end

  assign bus.pipe_ready  = !mdu_wins;
  assign bus.mdu_ready   = !full;
  assign bus.mdu_pending = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_regno[wr_ptr] <= bus.mdu_wregno;
      fifo_data[wr_ptr]  <= bus.mdu_regval;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (!head_valid || grant_mdu)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rf_we     <= 1'b0;
      bus.rf_wregno <= '0;
      bus.rf_wdata  <= '0;
    end else begin
      bus.rf_we <= grant_pipe || (grant_mdu && (head_regno != '0));
      if (grant_pipe) begin
        bus.rf_wregno <= bus.pipe_wregno;
        bus.rf_wdata  <= bus.pipe_regval;
      end else if (grant_mdu && (head_regno != '0)) begin
        bus.rf_wregno <= head_regno;
        bus.rf_wdata  <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based
// reference model of the write-port sharing rules.
module tb_wb_port_arbiter;

  localparam int unsigned DBITS  = 32;
  localparam int unsigned RBITS  = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned LIMIT  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DBITS(DBITS), .REGNOBITS(RBITS), .FIFO_DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .DBITS(DBITS), .REGNOBITS(RBITS), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: buffered MDU results, loss counter, last register-file write.
  int unsigned  q_reg[$];
  logic [31:0]  q_dat[$];
  int unsigned  m_starve;
  logic         m_we;
  int unsigned  m_regno;
  logic [31:0]  m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_reg.delete();
    q_dat.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_regno  = 0;
    m_data   = '0;
  endtask

  task automatic drive(input bit pv, input bit pwr, input int unsigned preg, input logic [31:0] pdat,
                       input bit mv, input int unsigned mreg, input logic [31:0] mdat);
    bus.pipe_valid  = pv;
    bus.pipe_wr_reg = pwr;
    bus.pipe_wregno = RBITS'(preg);
    bus.pipe_regval = pdat;
    bus.mdu_valid   = mv;
    bus.mdu_wregno  = RBITS'(mreg);
    bus.mdu_regval  = mdat;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: compare outputs against the model at the falling edge, then
  // advance the model by the arbitration rules and return just after the rising edge.
  task automatic cycle();
    bit need, hv, win, gm, gp;
    @(negedge clk);
    check("mdu_pending", bus.mdu_pending, q_reg.size());
    check("mdu_ready", bus.mdu_ready, q_reg.size() < DEPTH);
    check("rf_we", bus.rf_we, m_we);
    check("rf_wregno", bus.rf_wregno, m_regno);
    check("rf_wdata", bus.rf_wdata, m_data);
    need = bus.pipe_valid && bus.pipe_wr_reg && (bus.pipe_wregno != 0);
    hv   = q_reg.size() != 0;
    win  = need && hv && (m_starve >= LIMIT || q_reg.size() == DEPTH || q_reg[0] == bus.pipe_wregno);
    check("pipe_ready", bus.pipe_ready, !win);
    if (reset) begin
      gm = need ? win : hv;
      gp = need && !win;
      if (gp) begin
        m_we = 1'b1; m_regno = bus.pipe_wregno; m_data = bus.pipe_regval;
      end else if (gm && q_reg[0] != 0) begin
        m_we = 1'b1; m_regno = q_reg[0]; m_data = q_dat[0];
      end else
        m_we = 1'b0;
      if (!hv || gm) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      begin
        bit do_push;
        do_push = bus.mdu_valid && (q_reg.size() < DEPTH);
        if (gm) begin
          void'(q_reg.pop_front());
          void'(q_dat.pop_front());
        end
        if (do_push) begin
          q_reg.push_back(bus.mdu_wregno);
          q_dat.push_back(bus.mdu_regval);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    idle();

    // Reset with random inputs: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      cycle();
    end
    idle();
    reset = 1'b1;
    #1;
    check("idle_pipe_ready", bus.pipe_ready, 1);
    cycle();

    // WB-only write.
    drive(1, 1, 5, 32'h0000_1234, 0, 0, 0);
    #1 check("wb_pipe_ready", bus.pipe_ready, 1);
    cycle();
    idle();
    check("wb_rf_we", bus.rf_we, 1);
    check("wb_rf_wregno", bus.rf_wregno, 5);
    check("wb_rf_wdata", bus.rf_wdata, 32'h0000_1234);
    cycle();

    // Starvation: MDU x7 loses four times then is forced through.
    drive(0, 0, 0, 0, 1, 7, 32'hAA);
    cycle();
    drive(1, 1, 3, 32'h3333, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      #1 check("starve_pipe_wins", bus.pipe_ready, 1);
      cycle();
    end
    #1 check("starve_pipe_stall", bus.pipe_ready, 0);
    cycle();
    check("starve_rf_wregno", bus.rf_wregno, 7);
    check("starve_rf_wdata", bus.rf_wdata, 32'hAA);
    check("starve_pending", bus.mdu_pending, 0);
    cycle();
    idle();
    cycle();

    // Full FIFO: third result refused, MDU beats the pipe.
    drive(1, 1, 3, 32'h1, 1, 10, 32'h10);
    cycle();
    drive(1, 1, 3, 32'h2, 1, 11, 32'h11);
    cycle();
    drive(1, 1, 3, 32'h3, 1, 12, 32'h12);
    #1;
    check("full_mdu_ready", bus.mdu_ready, 0);
    check("full_pending", bus.mdu_pending, 2);
    check("full_pipe_ready", bus.pipe_ready, 0);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // Same-register ordering.
    drive(0, 0, 0, 0, 1, 9, 32'h11);
    cycle();
    drive(1, 1, 9, 32'h22, 0, 0, 0);
    #1 check("same_pipe_stall", bus.pipe_ready, 0);
    cycle();
    check("same_first_data", bus.rf_wdata, 32'h11);
    cycle();
    idle();
    check("same_second_data", bus.rf_wdata, 32'h22);
    check("same_second_reg", bus.rf_wregno, 9);
    cycle();

    // Bypass: non-writing WB passes while MDU x4 writes; x0 write suppressed.
    drive(0, 0, 0, 0, 1, 4, 32'h55);
    cycle();
    drive(1, 0, 6, 32'h66, 0, 0, 0);
    #1 check("nowr_pipe_ready", bus.pipe_ready, 1);
    cycle();
    drive(1, 1, 0, 32'h77, 0, 0, 0);
    check("bypass_rf_wregno", bus.rf_wregno, 4);
    check("bypass_rf_wdata", bus.rf_wdata, 32'h55);
    cycle();
    idle();
    check("x0_rf_we", bus.rf_we, 0);
    cycle();

    // Async reset with two entries buffered.
    drive(1, 1, 3, 32'h1, 1, 20, 32'h20);
    cycle();
    drive(1, 1, 3, 32'h2, 1, 21, 32'h21);
    cycle();
    idle();
    #2 reset = 1'b0;
    #1;
    model_clear();
    check("rst_pending", bus.mdu_pending, 0);
    check("rst_mdu_ready", bus.mdu_ready, 1);
    check("rst_rf_we", bus.rf_we, 0);
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic with a narrow register range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
